// File: rtl/pursue_match_ctrl.sv
// Match sequencer for the 16-LED pursuit game: step prescaler, countdown lamps,
// round judging (caught vs. survived), point/game scoring and match decision.
module pursue_match_ctrl #(
  parameter int TICK_DIV    = 12500000,
  parameter int COUNT_DIV   = 4,
  parameter int ROUND_STEPS = 64,
  parameter int HOLD_STEPS  = 8,
  parameter int WIN_POINTS  = 3,
  parameter int WIN_GAMES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       caught,
  output logic       step_tick,
  output logic       run_en,
  output logic       load_pos,
  output logic [7:0] cutdown_led,
  output logic       flash,
  output logic [1:0] pts_p,
  output logic [1:0] pts_c,
  output logic [1:0] games_p,
  output logic [1:0] games_c,
  output logic       match_over,
  output logic       winner
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STAGE_MAX = SW'(COUNT_DIV - 1);
  localparam logic [7:0]    STEP_MAX  = 8'(ROUND_STEPS - 1);
  localparam logic [7:0]    HOLD_MAX  = 8'(HOLD_STEPS - 1);
  localparam logic [1:0]    WIN_P     = 2'(WIN_POINTS);
  localparam logic [1:0]    WIN_G     = 2'(WIN_GAMES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RUN       = 3'd2,
    HOLD      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          start_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          step_tick_q, step_tick_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [7:0]    step_q, step_d;
  logic [7:0]    hold_q, hold_d;
  logic [7:0]    led_q, led_d;
  logic          load_pos_q, load_pos_d;
  logic          run_en_q, run_en_d;
  logic          flash_q, flash_d;
  logic [1:0]    pts_p_q, pts_p_d;
  logic [1:0]    pts_c_q, pts_c_d;
  logic [1:0]    games_p_q, games_p_d;
  logic [1:0]    games_c_q, games_c_d;
  logic          decided_q, decided_d;
  logic          match_over_q, match_over_d;
  logic          winner_q, winner_d;

  logic       start_edge;
  logic       enter_cd;
  logic       award_p;
  logic       award_c;
  logic [7:0] led_next;
  logic [1:0] pts_next;
  logic [1:0] games_next;

  assign start_edge = start & ~start_q;

  always_comb begin
    state_d    = state_q;
    presc_d    = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    stage_d    = stage_q;
    step_d     = step_q;
    hold_d     = hold_q;
    led_d      = led_q;
    load_pos_d = 1'b0;
    pts_p_d    = pts_p_q;
    pts_c_d    = pts_c_q;
    games_p_d  = games_p_q;
    games_c_d  = games_c_q;
    decided_d  = decided_q;
    winner_d   = winner_q;
    enter_cd   = 1'b0;
    award_p    = 1'b0;
    award_c    = 1'b0;
    led_next   = {1'b0, led_q[7:5], led_q[2:0], 1'b0};
    pts_next   = '0;
    games_next = '0;

    case (state_q)
      IDLE: begin
        if (start_edge) enter_cd = 1'b1;
      end
      COUNTDOWN: begin
        if (step_tick_q) begin
          if (stage_q == STAGE_MAX) begin
            stage_d = '0;
            led_d   = led_next;
            if (led_next == 8'h00) begin
              state_d = RUN;
              step_d  = '0;
            end
          end else begin
            stage_d = stage_q + SW'(1);
          end
        end
      end
      RUN: begin
        // caught has priority, so a catch on the final tick goes to the pursuer
        if (caught) begin
          award_p = 1'b1;
        end else if (step_tick_q) begin
          if (step_q == STEP_MAX) award_c = 1'b1;
          else                    step_d  = step_q + 8'd1;
        end
      end
      HOLD: begin
        if (step_tick_q) begin
          if (hold_q == HOLD_MAX) begin
            if (decided_q) state_d  = DONE;
            else           enter_cd = 1'b1;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      DONE: begin
        if (start_edge) begin
          pts_p_d   = '0;
          pts_c_d   = '0;
          games_p_d = '0;
          games_c_d = '0;
          decided_d = 1'b0;
          winner_d  = 1'b0;
          enter_cd  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (award_p) begin
      state_d  = HOLD;
      hold_d   = '0;
      pts_next = pts_p_q + 2'd1;
      if (pts_next == WIN_P) begin
        pts_p_d    = '0;
        pts_c_d    = '0;
        games_next = games_p_q + 2'd1;
        games_p_d  = games_next;
        if (games_next == WIN_G) begin
          decided_d = 1'b1;
          winner_d  = 1'b1;
        end
      end else begin
        pts_p_d = pts_next;
      end
    end else if (award_c) begin
      state_d  = HOLD;
      hold_d   = '0;
      pts_next = pts_c_q + 2'd1;
      if (pts_next == WIN_P) begin
        pts_p_d    = '0;
        pts_c_d    = '0;
        games_next = games_c_q + 2'd1;
        games_c_d  = games_next;
        if (games_next == WIN_G) begin
          decided_d = 1'b1;
          winner_d  = 1'b0;
        end
      end else begin
        pts_c_d = pts_next;
      end
    end

    // Countdown entry restarts the prescaler so stage timing is phase-exact
    if (enter_cd) begin
      state_d    = COUNTDOWN;
      led_d      = 8'hFF;
      load_pos_d = 1'b1;
      presc_d    = '0;
      stage_d    = '0;
    end

    step_tick_d  = (presc_d == PRESC_MAX);
    run_en_d     = (state_d == RUN);
    flash_d      = (state_d == HOLD);
    match_over_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      presc_q      <= '0;
      step_tick_q  <= 1'b0;
      stage_q      <= '0;
      step_q       <= '0;
      hold_q       <= '0;
      led_q        <= 8'h00;
      load_pos_q   <= 1'b0;
      run_en_q     <= 1'b0;
      flash_q      <= 1'b0;
      pts_p_q      <= '0;
      pts_c_q      <= '0;
      games_p_q    <= '0;
      games_c_q    <= '0;
      decided_q    <= 1'b0;
      match_over_q <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      presc_q      <= presc_d;
      step_tick_q  <= step_tick_d;
      stage_q      <= stage_d;
      step_q       <= step_d;
      hold_q       <= hold_d;
      led_q        <= led_d;
      load_pos_q   <= load_pos_d;
      run_en_q     <= run_en_d;
      flash_q      <= flash_d;
      pts_p_q      <= pts_p_d;
      pts_c_q      <= pts_c_d;
      games_p_q    <= games_p_d;
      games_c_q    <= games_c_d;
      decided_q    <= decided_d;
      match_over_q <= match_over_d;
      winner_q     <= winner_d;
    end
  end

  assign step_tick   = step_tick_q;
  assign run_en      = run_en_q;
  assign load_pos    = load_pos_q;
  assign cutdown_led = led_q;
  assign flash       = flash_q;
  assign pts_p       = pts_p_q;
  assign pts_c       = pts_c_q;
  assign games_p     = games_p_q;
  assign games_c     = games_c_q;
  assign match_over  = match_over_q;
  assign winner      = winner_q;

endmodule
